// File: rtl/pixel_state_ctrl_if.sv
// Row-readout handshake between the pixel sequencer (master) and the downstream consumer (slave).
interface pixel_state_ctrl_if #(
   parameter int unsigned W = 4
);
   logic [W*8-1:0] PIX_DATA;
   logic [7:0]     PIX_ROW;
   logic           PIX_VALID;
   logic           PIX_READY;

   modport master (output PIX_DATA, output PIX_ROW, output PIX_VALID, input PIX_READY);
   modport slave  (input PIX_DATA, input PIX_ROW, input PIX_VALID, output PIX_READY);
endinterface

// File: rtl/pixel_state_ctrl.sv
// Frame sequencer for a W x H pixel array: erase, expose, Gray-counted ramp conversion,
// then row-by-row readout with valid/ready backpressure.
module pixel_state_ctrl #(
   parameter int unsigned W          = 4,
   parameter int unsigned H          = 4,
   parameter int unsigned ERASE_CYC  = 5,
   parameter int unsigned EXPOSE_CYC = 255
) (
   input  logic                CLK,
   input  logic                RESETN,
   input  logic                START,
   output logic                ERASE,
   output logic                EXPOSE,
   output logic                CONVERT,
   output logic                CNT_OE,
   output logic [7:0]          CNT_VAL,
   output logic [H-1:0]        READBUS,
   input  logic [W*8-1:0]      DATA_IN,
   pixel_state_ctrl_if.master  pix,
   output logic                BUSY,
   output logic                FRAME_DONE
);

   typedef enum logic [2:0] {
      IDLE, ERASE_S, EXPOSE_S, CONV_S, RD_DRV, RD_CAP, DONE_S
   } state_t;

   state_t         state, state_nxt;
   logic [31:0]    cnt;
   logic [7:0]     b_nxt;
   logic [7:0]     row;
   logic [7:0]     cnt_val_q;
   logic [W*8-1:0] pix_data_q;
   logic [7:0]     pix_row_q;
   logic           pix_valid_q;
   logic           handshake;
   logic           last_row;

   assign handshake = pix_valid_q & pix.PIX_READY;
   assign last_row  = (row == 8'(H - 1));
   assign b_nxt     = cnt[7:0] + 8'd1;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ERASE      = 1'b0;
      EXPOSE     = 1'b0;
      CONVERT    = 1'b0;
      CNT_OE     = 1'b0;
      READBUS    = '0;
      BUSY       = 1'b1;
      FRAME_DONE = 1'b0;
      case (state)
         IDLE: begin
            BUSY = 1'b0;
            if (START) state_nxt = ERASE_S;
         end
         ERASE_S: begin
            ERASE = 1'b1;
            if (cnt == ERASE_CYC - 1) state_nxt = EXPOSE_S;
         end
         EXPOSE_S: begin
            EXPOSE = 1'b1;
            if (cnt == EXPOSE_CYC - 1) state_nxt = CONV_S;
         end
         CONV_S: begin
            CONVERT = 1'b1;
            CNT_OE  = 1'b1;
            if (cnt == 32'd255) state_nxt = RD_DRV;
         end
         RD_DRV: begin
            READBUS   = H'(1) << row;
            state_nxt = RD_CAP;
         end
         RD_CAP: begin
            if (handshake) state_nxt = last_row ? DONE_S : RD_DRV;
         end
         DONE_S: begin
            FRAME_DONE = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cnt restarts on every state change, so inside a timed phase it equals the
   // cycle offset; CNT_VAL is loaded with gray(b+1) so it stays aligned with b.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         cnt         <= '0;
         row         <= '0;
         cnt_val_q   <= '0;
         pix_data_q  <= '0;
         pix_row_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         if (state_nxt != state)
            cnt <= '0;
         else if (state == ERASE_S || state == EXPOSE_S || state == CONV_S)
            cnt <= cnt + 32'd1;

         if (state == CONV_S && state_nxt == CONV_S)
            cnt_val_q <= b_nxt ^ (b_nxt >> 1);
         else
            cnt_val_q <= '0;

         if (state == IDLE)
            row <= '0;
         else if (state == RD_CAP && handshake && !last_row)
            row <= row + 8'd1;

         if (state == RD_DRV) begin
            pix_data_q  <= DATA_IN;
            pix_row_q   <= row;
            pix_valid_q <= 1'b1;
         end else if (handshake) begin
            pix_valid_q <= 1'b0;
         end
      end
   end

   assign CNT_VAL       = cnt_val_q;
   assign pix.PIX_DATA  = pix_data_q;
   assign pix.PIX_ROW   = pix_row_q;
   assign pix.PIX_VALID = pix_valid_q;

endmodule

// File: tb/tb_pixel_state_ctrl.sv
// Self-checking bench: each frame is checked against a phase schedule computed from
// the phase lengths, with a per-row expected-data record and randomized START/READY/DATA_IN.
module tb_pixel_state_ctrl;
   localparam int unsigned W = 4;
   localparam int unsigned H = 4;
   localparam int unsigned E = 5;
   localparam int unsigned X = 255;

   logic           CLK    = 1'b0;
   logic           RESETN = 1'b1;
   logic           START  = 1'b0;
   logic           ERASE, EXPOSE, CONVERT, CNT_OE, BUSY, FRAME_DONE;
   logic [7:0]     CNT_VAL;
   logic [H-1:0]   READBUS;
   logic [W*8-1:0] DATA_IN = '0;

   int n_checks = 0;
   int n_pass   = 0;

   pixel_state_ctrl_if #(.W(W)) pix ();

   pixel_state_ctrl #(
      .W(W), .H(H), .ERASE_CYC(E), .EXPOSE_CYC(X)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .START(START),
      .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT), .CNT_OE(CNT_OE),
      .CNT_VAL(CNT_VAL), .READBUS(READBUS), .DATA_IN(DATA_IN), .pix(pix),
      .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   // ctrl = {ERASE, EXPOSE, CONVERT, CNT_OE, BUSY, FRAME_DONE}
   task automatic expect_ctrl(input string tag, input logic [5:0] ctrl,
                              input logic [7:0] cv, input logic [H-1:0] rb);
      check({tag, "_ctrl"}, {ERASE, EXPOSE, CONVERT, CNT_OE, BUSY, FRAME_DONE}, ctrl);
      check({tag, "_cnt_val"}, CNT_VAL, cv);
      check({tag, "_readbus"}, READBUS, rb);
   endtask

   task automatic rand_data();
      for (int unsigned j = 0; j < W; j++) DATA_IN[j*8 +: 8] = 8'($urandom);
   endtask

   task automatic run_frame(input bit hold, input bit pat, input bit rnd_ready,
                            input int stall1, input int abort_b);
      logic [W*8-1:0] exp_data;
      logic [H-1:0]   exp_rb;
      logic [7:0]     prev_cv;
      int unsigned    g;
      bit             rdy;
      START = 1'b1;
      step();
      for (int unsigned k = 0; k < E; k++) begin
         expect_ctrl("erase", 6'b100010, 8'h00, '0);
         START = hold ? 1'b1 : 1'($urandom);
         rand_data();
         step();
      end
      for (int unsigned k = 0; k < X; k++) begin
         expect_ctrl("expose", 6'b010010, 8'h00, '0);
         START = hold ? 1'b1 : 1'($urandom);
         step();
      end
      prev_cv = 8'h00;
      for (int unsigned b = 0; b < 256; b++) begin
         g = b ^ (b >> 1);
         expect_ctrl("conv", 6'b001110, 8'(g), '0);
         if (b > 0) check("gray_1bit", 64'($countones(CNT_VAL ^ prev_cv)), 64'd1);
         if (b == 255) check("gray_last", CNT_VAL, 8'h80);
         prev_cv = CNT_VAL;
         if (int'(b) == abort_b) begin
            #2 RESETN = 1'b0;
            #1;
            expect_ctrl("rst_async", 6'b000000, 8'h00, '0);
            check("rst_pix_valid", pix.PIX_VALID, 1'b0);
            check("rst_pix_row", pix.PIX_ROW, 8'h00);
            check("rst_pix_data", pix.PIX_DATA, '0);
            START = 1'b0;
            @(negedge CLK);
            RESETN = 1'b1;
            for (int i = 0; i < 3; i++) begin
               step();
               expect_ctrl("rst_idle", 6'b000000, 8'h00, '0);
            end
            return;
         end
         START = hold ? 1'b1 : 1'($urandom);
         step();
      end
      for (int unsigned row = 0; row < H; row++) begin
         exp_rb = '0;
         exp_rb[row] = 1'b1;
         expect_ctrl("rd_drv", 6'b000010, 8'h00, exp_rb);
         check("rd_drv_valid", pix.PIX_VALID, 1'b0);
         for (int unsigned j = 0; j < W; j++)
            DATA_IN[j*8 +: 8] = pat ? 8'(16*j + row) : 8'($urandom);
         exp_data = DATA_IN;
         pix.PIX_READY = 1'($urandom);
         step();
         for (int c = 0; c < 64; c++) begin
            expect_ctrl("rd_cap", 6'b000010, 8'h00, '0);
            check("pix_valid", pix.PIX_VALID, 1'b1);
            check("pix_row", pix.PIX_ROW, 8'(row));
            check("pix_data", pix.PIX_DATA, exp_data);
            rand_data();
            if (row == 1 && c < stall1) rdy = 1'b0;
            else if (rnd_ready && c < 32) rdy = 1'($urandom);
            else rdy = 1'b1;
            pix.PIX_READY = rdy;
            step();
            if (rdy) break;
         end
      end
      expect_ctrl("done", 6'b000011, 8'h00, '0);
      check("done_valid", pix.PIX_VALID, 1'b0);
      START = hold;
      step();
      expect_ctrl("idle_gap", 6'b000000, 8'h00, '0);
   endtask

   initial begin
      pix.PIX_READY = 1'b1;
      #1 RESETN = 1'b0;
      #2;
      expect_ctrl("reset", 6'b000000, 8'h00, '0);
      check("reset_pix_valid", pix.PIX_VALID, 1'b0);
      check("reset_pix_row", pix.PIX_ROW, 8'h00);
      step();
      step();
      RESETN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_ctrl("idle_wait", 6'b000000, 8'h00, '0);
      end
      // nominal with column pattern, then row-1 backpressure, then abort at b=100
      run_frame(1'b0, 1'b1, 1'b0, 0, -1);
      run_frame(1'b0, 1'b1, 1'b0, 10, -1);
      run_frame(1'b0, 1'b0, 1'b1, 0, 100);
      run_frame(1'b0, 1'b0, 1'b1, 0, -1);
      run_frame(1'b1, 1'b0, 1'b0, 0, -1);
      run_frame(1'b1, 1'b0, 1'b1, 0, -1);
      run_frame(1'b0, 1'b0, 1'b1, 3, -1);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_ctrl("tail_idle", 6'b000000, 8'h00, '0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pixel_state_ctrl.md
PIXEL_STATE_CTRL -- requirements
Module: pixel_state_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: pixel columns; DATA_IN/PIX_DATA width = W*8.
REQ-002 SHALL have parameter H, default 4: pixel rows; READBUS width = H, H <= 256.
REQ-003 SHALL have parameter ERASE_CYC, default 5: ERASE phase length in cycles, >= 1.
REQ-004 SHALL have parameter EXPOSE_CYC, default 255: EXPOSE phase length in cycles, >= 1.
REQ-005 SHALL have port CLK  input  1: single clock, all state updates on rising edge.
REQ-006 SHALL have port RESETN  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port START  input  1: frame request, sampled in IDLE only.
REQ-008 SHALL have port ERASE  output  1: pixel erase strobe.
REQ-009 SHALL have port EXPOSE  output  1: pixel exposure enable.
REQ-010 SHALL have port CONVERT  output  1: ramp-run / conversion window.
REQ-011 SHALL have port CNT_OE  output  1: high while CNT_VAL is to be driven onto the pixel data bus.
REQ-012 SHALL have port CNT_VAL  output  8: Gray-coded conversion count.
REQ-013 SHALL have port READBUS  output  H: one-hot row select into the pixel array.
REQ-014 SHALL have port DATA_IN  input  W*8: pixel data bus value, column j at bits [j*8 +: 8].
REQ-015 SHALL have port PIX_DATA  output  W*8: captured row data.
REQ-016 SHALL have port PIX_ROW  output  8: row index of PIX_DATA.
REQ-017 SHALL have port PIX_VALID  output  1: PIX_DATA/PIX_ROW valid.
REQ-018 SHALL have port PIX_READY  input  1: downstream accepts when PIX_VALID & PIX_READY.
REQ-019 SHALL have port BUSY  output  1: high in every state except IDLE.
REQ-020 SHALL have port FRAME_DONE  output  1: one-cycle pulse at frame end.

Function
REQ-021 SHALL implement states IDLE, ERASE_S, EXPOSE_S, CONV_S, RD_DRV, RD_CAP, DONE_S.
REQ-022 SHALL go IDLE->ERASE_S on the edge where START=1; START in other states ignored.
REQ-023 SHALL hold ERASE=1 for exactly ERASE_CYC cycles in ERASE_S, then go EXPOSE_S.
REQ-024 SHALL hold EXPOSE=1 for exactly EXPOSE_CYC cycles in EXPOSE_S, then go CONV_S.
REQ-025 SHALL in CONV_S hold CONVERT=1, CNT_OE=1 for exactly 256 cycles; binary count b steps 0..255, one per cycle.
REQ-026 SHALL drive CNT_VAL = b XOR (b>>1) registered; CNT_VAL=0 outside CONV_S.
REQ-027 SHALL after b=255 go RD_DRV with row pointer r=0; CNT_OE and CONVERT low from that cycle.
REQ-028 SHALL in RD_DRV assert READBUS[r] only, for 1 settle cycle, then go RD_CAP.
REQ-029 SHALL on entering RD_CAP register DATA_IN into PIX_DATA, r into PIX_ROW, set PIX_VALID=1, drop READBUS to 0.
REQ-030 SHALL hold PIX_DATA, PIX_ROW, PIX_VALID stable until the PIX_VALID & PIX_READY cycle.
REQ-031 SHALL on handshake clear PIX_VALID next cycle; r<H-1: r+1, go RD_DRV; r=H-1: go DONE_S.
REQ-032 SHALL in DONE_S pulse FRAME_DONE=1 for one cycle, then return IDLE.
REQ-033 SHALL keep ERASE, EXPOSE, CONVERT, CNT_OE mutually exclusive; READBUS zero outside RD_DRV.
REQ-034 SHALL with PIX_READY held high give 2 cycles per row, PIX_VALID high 1 cycle per row.
REQ-035 SHALL with PIX_READY low stall indefinitely in RD_CAP, no data loss, no extra row select.
REQ-036 SHALL emit exactly H accepted rows per frame, rows in order 0..H-1.

Reset
REQ-037 SHALL on RESETN=0, at any time incl. mid-frame, immediately force IDLE, all outputs 0, counters and r to 0.
REQ-038 SHALL after RESETN release stay IDLE until START=1; an aborted frame is not resumed.

Verification
REQ-039 SHALL cover nominal frame (H=4, defaults, READY=1): ERASE 5 cyc -> EXPOSE 255 -> CONVERT 256 -> 4 rows at 2 cyc each, PIX_ROW 0,1,2,3, FRAME_DONE once.
REQ-040 SHALL cover Gray check: CNT_VAL sequence 0,1,3,2,6,... ends 0x80 at b=255; exactly one bit changes per step.
REQ-041 SHALL cover backpressure: READY low 10 cycles on row 1 -> PIX_DATA/PIX_ROW=1 stable, READBUS=0, no row 2 select until handshake.
REQ-042 SHALL cover data capture: DATA_IN column j = 0x10*j + row in RD_DRV -> PIX_DATA matches per row.
REQ-043 SHALL cover reset mid-CONV_S (b=100): all outputs 0 asynchronously; new START -> full ERASE_S restart.
REQ-044 SHALL cover START held high continuously -> back-to-back frames, exactly one IDLE cycle between FRAME_DONE and next ERASE.
